// File: rtl/alu_stream_core_if.sv
// Stream handshake bundle for alu_stream_core: operand input channel and result/flags output channel.
interface alu_stream_core_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, count
  );
endinterface

// File: rtl/alu_stream_core.sv
// Streaming ALU: operand register, single compute stage, result FIFO with credit-based input throttling.
// Define ALU_STREAM_MUL_EN to make opcode 111 a multiply; otherwise it is flagged illegal.
module alu_stream_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  alu_stream_core_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef logic [WIDTH-1:0] word_t;

  logic          s1_valid_q, s1_valid_d;
  logic [2:0]    s1_op_q, s1_op_d;
  word_t         s1_a_q, s1_a_d;
  word_t         s1_b_q, s1_b_d;
  word_t         acc_q, acc_d;
  word_t         res_mem_q [DEPTH];
  word_t         res_mem_d [DEPTH];
  logic [2:0]    flg_mem_q [DEPTH];
  logic [2:0]    flg_mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          in_ready_c, in_fire, out_fire, push;
  logic [WIDTH:0] sum_w;
  word_t         c_res;
  logic          c_carry, c_ovf, c_zero;
`ifdef ALU_STREAM_MUL_EN
  logic [2*WIDTH-1:0] prod_w;
`endif

  // Credit check counts the op sitting in stage 1, so a full FIFO can never be overrun.
  assign in_ready_c = rst_n && ena && (({1'b0, count_q} + {{CW{1'b0}}, s1_valid_q}) < DEPTH_C);
  assign in_fire    = bus.in_valid && in_ready_c;
  assign out_fire   = (count_q != '0) && bus.out_ready;
  assign push       = s1_valid_q;

  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    sum_w   = '0;
    acc_d   = acc_q;
`ifdef ALU_STREAM_MUL_EN
    prod_w  = '0;
`endif
    case (s1_op_q)
      3'b000: begin
        sum_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        c_res   = sum_w[WIDTH-1:0];
        c_carry = sum_w[WIDTH];
        c_ovf   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (c_res[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      3'b001: begin
        sum_w   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        c_res   = sum_w[WIDTH-1:0];
        c_carry = sum_w[WIDTH];
        c_ovf   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (c_res[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      3'b010: c_res = s1_a_q & s1_b_q;
      3'b011: c_res = s1_a_q | s1_b_q;
      3'b100: c_res = s1_a_q ^ s1_b_q;
      3'b101: begin
        sum_w   = {1'b0, acc_q} + {1'b0, s1_a_q};
        c_res   = sum_w[WIDTH-1:0];
        c_carry = sum_w[WIDTH];
        c_ovf   = (acc_q[WIDTH-1] == s1_a_q[WIDTH-1]) && (c_res[WIDTH-1] != acc_q[WIDTH-1]);
        if (s1_valid_q) acc_d = c_res;
      end
      3'b110: begin
        if (s1_valid_q) acc_d = '0;
      end
      default: begin
`ifdef ALU_STREAM_MUL_EN
        prod_w  = s1_a_q * s1_b_q;
        c_res   = prod_w[WIDTH-1:0];
        c_carry = |prod_w[2*WIDTH-1:WIDTH];
`else
        c_ovf   = 1'b1;
`endif
      end
    endcase
    c_zero = (c_res == '0);
  end

  always_comb begin
    s1_valid_d = in_fire;
    s1_op_d    = in_fire ? bus.op : s1_op_q;
    s1_a_d     = in_fire ? bus.a  : s1_a_q;
    s1_b_d     = in_fire ? bus.b  : s1_b_q;
    res_mem_d  = res_mem_q;
    flg_mem_d  = flg_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      res_mem_d[wr_ptr_q] = c_res;
      flg_mem_d[wr_ptr_q] = {c_ovf, c_carry, c_zero};
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end
    if (out_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, out_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      acc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= '0;
        flg_mem_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      acc_q      <= acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      res_mem_q  <= res_mem_d;
      flg_mem_q  <= flg_mem_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (count_q != '0);
  assign bus.result    = res_mem_q[rd_ptr_q];
  assign bus.flags     = flg_mem_q[rd_ptr_q];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_alu_stream_core.sv
// Directed bench for alu_stream_core (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_alu_stream_core;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  alu_stream_core_if #(.WIDTH(W), .DEPTH(D)) bus ();
  alu_stream_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] v_op  [8];
  logic [7:0] v_a   [8];
  logic [7:0] v_b   [8];
  logic [7:0] v_res [8];
  logic [2:0] v_flg [8];
  logic [7:0] got   [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] res, input logic [2:0] flg);
    v_op[i] = op; v_a[i] = a; v_b[i] = b; v_res[i] = res; v_flg[i] = flg;
  endtask

  // Issues n vectors back to back with the consumer always ready; each result
  // must be at the FIFO head exactly one edge after its own push edge.
  task automatic stream(input int n, input string tag);
    bus.out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.in_valid = 1'b1;
        bus.op = v_op[i];
        bus.a  = v_a[i];
        bus.b  = v_b[i];
        check($sformatf("%s%0d_in_ready", tag, i), {31'd0, bus.in_ready}, 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i > 0) begin
        check($sformatf("%s%0d_valid", tag, i - 1), {31'd0, bus.out_valid}, 32'd1);
        check($sformatf("%s%0d_result", tag, i - 1), {24'd0, bus.result}, {24'd0, v_res[i - 1]});
        check($sformatf("%s%0d_flags", tag, i - 1), {29'd0, bus.flags}, {29'd0, v_flg[i - 1]});
      end
    end
    tick();
    check({tag, "_drained"}, {29'd0, bus.count}, 32'd0);
  endtask

  initial begin
    int j;
    int k;
    logic fi;
    logic fo;

    rst_n = 1'b0;
    ena = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #2;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_count", {29'd0, bus.count}, 32'd0);
    check("rst_result", {24'd0, bus.result}, 32'd0);
    check("rst_flags", {29'd0, bus.flags}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Scenario 1: single ADD, latency of two edges to out_valid
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = 3'b000; bus.a = 8'd3; bus.b = 8'd2;
    tick();
    bus.in_valid = 1'b0;
    check("add1_not_yet_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("add1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("add1_result", {24'd0, bus.result}, 32'h05);
    check("add1_flags", {29'd0, bus.flags}, 32'd0);
    tick();
    check("add1_popped", {31'd0, bus.out_valid}, 32'd0);

    // Scenario 2: back-to-back SUB / ADD / XOR
    set_vec(0, 3'b001, 8'h01, 8'h04, 8'hFD, 3'b010);
    set_vec(1, 3'b000, 8'h7F, 8'h01, 8'h80, 3'b100);
    set_vec(2, 3'b100, 8'h05, 8'h05, 8'h00, 3'b001);
    set_vec(3, 3'b010, 8'hF0, 8'h3C, 8'h30, 3'b000);
    set_vec(4, 3'b011, 8'hA0, 8'h05, 8'hA5, 3'b000);
    set_vec(5, 3'b000, 8'hFF, 8'h01, 8'h00, 3'b011);
    stream(6, "b2b");

    // Scenario 3: accumulator chain
    set_vec(0, 3'b110, 8'h55, 8'h00, 8'h00, 3'b001);
    set_vec(1, 3'b101, 8'h07, 8'h00, 8'h07, 3'b000);
    set_vec(2, 3'b101, 8'h02, 8'h00, 8'h09, 3'b000);
    set_vec(3, 3'b101, 8'hF8, 8'h00, 8'h01, 3'b010);
    stream(4, "acc");

    // Scenario 4: backpressure with 6 ADDs of a=j, b=0x10
    bus.out_ready = 1'b0;
    bus.op = 3'b000;
    bus.b = 8'h10;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'(j);
      fi = bus.in_ready;
      tick();
      if (fi) j++;
    end
    check("bp_accepted", j, 32'd4);
    check("bp_count_full", {29'd0, bus.count}, 32'd4);
    check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    check("bp_head", {24'd0, bus.result}, 32'h10);
    bus.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && (j < 6 || k < 6); c++) begin
      bus.in_valid = (j < 6);
      bus.a = 8'(j);
      fi = bus.in_valid && bus.in_ready;
      fo = bus.out_valid;
      if (fo) got[k] = bus.result;
      tick();
      if (fi) j++;
      if (fo) k++;
      if (c == 0) check("bp_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    check("bp_total_accepted", j, 32'd6);
    check("bp_total_drained", k, 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("bp_order%0d", i), {24'd0, got[i]}, 32'h10 + 32'(i));
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Scenario 5: opcode 111
`ifdef ALU_STREAM_MUL_EN
    set_vec(0, 3'b111, 8'h10, 8'h11, 8'h10, 3'b010);
`else
    set_vec(0, 3'b111, 8'h10, 8'h11, 8'h00, 3'b101);
`endif
    stream(1, "op7");

    ena = 1'b0;
    #1;
    check("ena_low_in_ready", {31'd0, bus.in_ready}, 32'd0);
    ena = 1'b1;
    #1;
    check("ena_high_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Scenario 6: reset mid-operation with 3 queued entries and acc=9
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = 3'b110; bus.a = 8'h00;
    tick();
    bus.op = 3'b101; bus.a = 8'h07;
    tick();
    bus.op = 3'b101; bus.a = 8'h02;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mid_count3", {29'd0, bus.count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_count", {29'd0, bus.count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    set_vec(0, 3'b101, 8'h01, 8'h00, 8'h01, 3'b000);
    stream(1, "post_rst_acc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
